// File: rtl/regfile_mp.sv
// Multi-read-port register file with x0 hardwired to zero, a per-register busy scoreboard
// and a post-reset clear sequencer. Define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
module regfile_mp #(
   parameter  int DATA_WIDTH = 64,
   parameter  int DEPTH      = 32,
   parameter  int NUM_READ   = 2,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           we,
   input  logic [ADDR_WIDTH-1:0]          waddr,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
   output logic [NUM_READ-1:0]            rbusy,
   input  logic                           issue_valid,
   input  logic [ADDR_WIDTH-1:0]          issue_rd,
   input  logic                           flush,
   output logic                           ready
);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DEPTH-1:0]      busy_q, busy_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] ra [NUM_READ];
   logic                  wr_en;
   logic                  iss_en;

   assign ready  = (state_q == ST_RUN);
   assign wr_en  = ready && we && (waddr != '0);
   assign iss_en = ready && issue_valid && (issue_rd != '0);

   for (genvar g = 0; g < NUM_READ; g++) begin : g_raddr
      assign ra[g] = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + ADDR_WIDTH'(1);
         if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_RUN;
      end
   end

   // Flush first, then writeback clear, then issue set: a new producer wins over both.
   always_comb begin
      busy_d = busy_q;
      if (flush)  busy_d           = '0;
      if (wr_en)  busy_d[waddr]    = 1'b0;
      if (iss_en) busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   // NOTE: storage has no reset term so it can map to RAM; the INIT sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         if (ready) begin
            if (ra[i] != '0) rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra[i]];
            rbusy[i] = busy_q[ra[i]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (ra[i] == waddr)) begin
               rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
               if (!(issue_valid && (issue_rd == waddr))) rbusy[i] = 1'b0;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against a cycle-level behavioural model.
module tb_regfile_mp;

   localparam int DW    = 64;
   localparam int DEPTH = 32;
   localparam int NR    = 2;
   localparam int AW    = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [DW-1:0]    wdata;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]    rbusy;
   logic             issue_valid;
   logic [AW-1:0]    issue_rd;
   logic             flush;
   logic             ready;

   regfile_mp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_READ(NR)) dut (
      .clk         (clk),
      .reset       (reset),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .raddr       (raddr),
      .rdata       (rdata),
      .rbusy       (rbusy),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .flush       (flush),
      .ready       (ready)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: architectural contents, busy set, and cycles since reset release.
   logic [DW-1:0] m_mem  [DEPTH];
   bit            m_busy [DEPTH];
   int            m_init_cycles;
   bit            m_ready;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
      if (!m_ready || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we && waddr != 0 && a == waddr) return wdata;
`endif
      return m_mem[a];
   endfunction

   function automatic logic exp_rbusy(input logic [AW-1:0] a);
      logic b;
      if (!m_ready) return 1'b0;
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (we && waddr != 0 && a == waddr && !(issue_valid && issue_rd == waddr)) b = 1'b0;
`endif
      return b;
   endfunction

   task automatic model_reset();
      m_ready       = 1'b0;
      m_init_cycles = 0;
      for (int r = 0; r < DEPTH; r++) m_busy[r] = 1'b0;
   endtask

   task automatic model_edge();
      if (!m_ready) begin
         m_init_cycles++;
         if (m_init_cycles == DEPTH) begin
            m_ready = 1'b1;
            for (int r = 0; r < DEPTH; r++) m_mem[r] = '0;
         end
      end else begin
         if (flush) for (int r = 0; r < DEPTH; r++) m_busy[r] = 1'b0;
         if (we && waddr != 0) begin
            m_mem[waddr]  = wdata;
            m_busy[waddr] = 1'b0;
         end
         if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
   endtask

   // Called at a falling edge with inputs already driven: check outputs, clock once, update model.
   task automatic step(input string tag);
      logic [AW-1:0] a;
      #1;
      check({tag, "_ready"}, {63'b0, ready}, {63'b0, m_ready});
      for (int p = 0; p < NR; p++) begin
         a = raddr[p*AW +: AW];
         check({tag, "_rdata"}, rdata[p*DW +: DW], exp_rdata(a));
         check({tag, "_rbusy"}, {63'b0, rbusy[p]}, {63'b0, exp_rbusy(a)});
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      we = 1'b0; waddr = '0; wdata = '0; issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      raddr = {a1, a0};
   endtask

   task automatic random_inputs();
      we          = 1'($urandom_range(0, 1));
      waddr       = AW'($urandom_range(0, DEPTH - 1));
      wdata       = {$urandom, $urandom};
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = AW'($urandom_range(0, DEPTH - 1));
      flush       = ($urandom_range(0, 15) == 0);
      raddr[0 +: AW]  = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
      raddr[AW +: AW] = ($urandom_range(0, 3) == 0) ? issue_rd : AW'($urandom_range(0, DEPTH - 1));
   endtask

   // Runs the clear sequence; junk inputs must have no visible effect while not ready.
   task automatic run_init(input bit junk);
      int low = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (junk) random_inputs();
         if (ready === 1'b0) low++;
         step("init");
      end
      check("init_low_cycles", DW'(low), DW'(DEPTH));
      idle_inputs();
      #1;
      check("init_ready_up", {63'b0, ready}, 64'd1);
   endtask

   task automatic read_all_zero(input string tag);
      for (int a = 0; a < DEPTH; a += 2) begin
         set_rd(AW'(a), AW'(a + 1));
         step(tag);
         check({tag, "_p0"}, rdata[0 +: DW], '0);
         check({tag, "_p1"}, rdata[DW +: DW], '0);
      end
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      reset = 1'b0;
      idle_inputs();
      raddr = '0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready", {63'b0, ready}, 64'd0);

      // INIT with a held write that must be discarded
      reset = 1'b1;
      we = 1'b1; waddr = 5'd5; wdata = 64'hAA;
      issue_valid = 1'b1; issue_rd = 5'd5;
      set_rd(5'd5, 5'd5);
      run_init(1'b0);
      set_rd(5'd5, 5'd0);
      #1;
      check("init_reg5_zero", rdata[0 +: DW], '0);
      check("init_reg5_idle", {63'b0, rbusy[0]}, 64'd0);
      read_all_zero("init_sweep");

      // Write/read and x0
      we = 1'b1; waddr = 5'd7; wdata = 64'h1234_5678_9ABC_DEF0;
      step("wr7");
      idle_inputs();
      set_rd(5'd7, 5'd7);
      #1;
      check("rd7_p0", rdata[0 +: DW], 64'h1234_5678_9ABC_DEF0);
      check("rd7_p1", rdata[DW +: DW], 64'h1234_5678_9ABC_DEF0);
      we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF;
      step("wr0");
      idle_inputs();
      set_rd(5'd0, 5'd0);
      #1;
      check("rd0_p0", rdata[0 +: DW], '0);
      check("rd0_p1", rdata[DW +: DW], '0);

      // Same-cycle write and read of reg 3
      we = 1'b1; waddr = 5'd3; wdata = 64'h55;
      set_rd(5'd3, 5'd7);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_same", rdata[0 +: DW], 64'h55);
`else
      check("byp_same", rdata[0 +: DW], 64'h0);
`endif
      step("byp");
      idle_inputs();
      #1;
      check("byp_next", rdata[0 +: DW], 64'h55);

      // Scoreboard set / set-wins / clear / x0
      issue_valid = 1'b1; issue_rd = 5'd9;
      step("iss9");
      idle_inputs();
      set_rd(5'd9, 5'd9);
      #1;
      check("busy9_set", {63'b0, rbusy[0]}, 64'd1);
      we = 1'b1; waddr = 5'd9; wdata = 64'h99;
      issue_valid = 1'b1; issue_rd = 5'd9;
      step("wb_iss9");
      idle_inputs();
      #1;
      check("busy9_setwins", {63'b0, rbusy[0]}, 64'd1);
      we = 1'b1; waddr = 5'd9; wdata = 64'h9A;
      step("wb9");
      idle_inputs();
      #1;
      check("busy9_clr", {63'b0, rbusy[0]}, 64'd0);
      issue_valid = 1'b1; issue_rd = 5'd0;
      step("iss0");
      idle_inputs();
      set_rd(5'd0, 5'd0);
      #1;
      check("busy0", {63'b0, rbusy[0]}, 64'd0);

      // Flush with a same-cycle issue
      for (int r = 2; r <= 6; r += 2) begin
         we = 1'b1; waddr = AW'(r); wdata = 64'hC0DE_0000 + DW'(r);
         step("fl_wr");
      end
      for (int r = 2; r <= 6; r += 2) begin
         idle_inputs();
         issue_valid = 1'b1; issue_rd = AW'(r);
         step("fl_iss");
      end
      idle_inputs();
      flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4;
      step("flush");
      idle_inputs();
      set_rd(5'd2, 5'd4);
      #1;
      check("fl_busy2", {63'b0, rbusy[0]}, 64'd0);
      check("fl_busy4", {63'b0, rbusy[1]}, 64'd1);
      check("fl_data2", rdata[0 +: DW], 64'hC0DE_0002);
      check("fl_data4", rdata[DW +: DW], 64'hC0DE_0004);
      set_rd(5'd6, 5'd6);
      step("fl_rd6");
      check("fl_busy6", {63'b0, rbusy[0]}, 64'd0);
      check("fl_data6", rdata[0 +: DW], 64'hC0DE_0006);

      // Randomised run against the model
      for (int n = 0; n < 1500; n++) begin
         random_inputs();
         step("rand");
      end

      // Reset mid-operation with regs 2 and 4 busy
      idle_inputs();
      issue_valid = 1'b1; issue_rd = 5'd2;
      step("rst_iss2");
      issue_rd = 5'd4;
      step("rst_iss4");
      idle_inputs();
      set_rd(5'd2, 5'd4);
      #1;
      check("rst_pre_busy2", {63'b0, rbusy[0]}, 64'd1);
      #1;
      reset = 1'b0;
      #1;
      check("rst_async_ready", {63'b0, ready}, 64'd0);
      check("rst_async_busy", {62'b0, rbusy}, 64'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      run_init(1'b1);
      set_rd(5'd2, 5'd4);
      #1;
      check("rst_busy_clr", {62'b0, rbusy}, 64'd0);
      read_all_zero("rst_sweep");

      // Short randomised run after the second INIT
      for (int n = 0; n < 300; n++) begin
         random_inputs();
         step("rand2");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-issue integer register file.
- Supports N combinational read ports and one synchronous write port, with register 0 hardwired to zero.
- Adds a per-register busy scoreboard for pipelined hazard detection.
- Adds a post-reset clear sequencer, so storage carries no reset and can map to RAM.
- Sits in ID; writeback drives the write port, and issue logic drives the scoreboard.

Parameters:
- DATA_WIDTH, 64, register width in bits.
- DEPTH, 32, number of architectural registers; must be a power of two, at least 2.
- ADDR_WIDTH, $clog2(DEPTH), register address width; derived, never overridden.
- NUM_READ, 2, number of read ports, 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous release.
- we  in  1  write enable (writeback).
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- raddr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_READ*DATA_WIDTH  packed read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rbusy  out  NUM_READ  per-port busy flag of the addressed register.
- issue_valid  in  1  an instruction with a destination issues this cycle.
- issue_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- flush  in  1  pipeline flush; clears the scoreboard.
- ready  out  1  high once initialisation is complete.

Behaviour:
- State machine: INIT -> RUN.
  - Reset (reset=0) forces INIT, sets clear counter cnt=0, clears all busy bits, and sets ready=0. It does not touch storage.
  - In INIT, each cycle writes 0 to register cnt, then cnt++.
  - When cnt==DEPTH-1 is written, the next state is RUN.
  - INIT lasts exactly DEPTH cycles after reset release; ready rises at the edge ending the last clear write.
  - RUN has no exit except reset. Reset asserted mid-INIT or mid-RUN restarts INIT from cnt=0.
- While ready=0:
  - we and issue_valid are ignored.
  - rdata is all zeros and rbusy is all zeros.
- Write, in RUN: if we and waddr!=0, storage[waddr] <= wdata at the rising edge. A write to address 0 is discarded.
- Read is combinational with zero latency:
  - rdata_i = 0 if raddr_i==0, else storage[raddr_i].
  - All ports are independent; multiple ports may address the same register.
- Scoreboard: busy[DEPTH-1:1], with busy[0] constant 0.
  - Set: issue_valid && issue_rd!=0 && ready sets busy[issue_rd].
  - Clear: we && waddr!=0 && ready clears busy[waddr].
  - Set and clear to the same register in the same cycle: set wins (a new producer supersedes the old one).
  - flush clears all busy bits. An issue in the same cycle as flush still sets its bit (issue is ordered after flush).
  - flush does not affect storage or a same-cycle write.
- rbusy_i = busy[raddr_i], subject to the bypass rule under the optional feature.
- Storage has no reset term. Values after reset are defined only through the INIT sequence.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding: when we && ready && waddr!=0 && raddr_i==waddr, rdata_i = wdata in the same cycle.
  - rbusy_i is forced to 0 in that case, unless issue_valid && issue_rd==waddr in the same cycle.
- Undefined:
  - Reads return the pre-write storage value; the new value is visible from the cycle after the edge.
  - rbusy_i shows the registered busy bit; it drops the cycle after writeback.

Test Plan:
- INIT sequence, DEPTH=32: release reset, hold we=1, waddr=5, wdata=0xAA.
  - ready=0 for exactly 32 cycles, then 1.
  - The write is ignored; reading reg 5 afterwards gives 0.
  - All 32 registers read 0.
- Write/read and x0 in RUN:
  - Write 0x1234_5678_9ABC_DEF0 to reg 7; the next cycle both ports at address 7 read that value.
  - Write 0xFFFF to reg 0; port reads of reg 0 return 0.
- Bypass: in one cycle set we=1, waddr=3, wdata=0x55 and raddr0=3.
  - With REGFILE_BYPASS_EN: rdata0=0x55 in the same cycle.
  - Without it: rdata0 holds the old value that cycle, and 0x55 from the next cycle.
- Scoreboard:
  - Issue rd=9; the next cycle rbusy for raddr=9 is 1.
  - Writeback to 9 together with a new issue to rd=9 in the same cycle: busy stays 1.
  - A writeback alone clears it.
  - Issue rd=0 leaves rbusy=0.
- Flush: set busy on regs 2, 4, 6, then assert flush together with issue rd=4.
  - Afterwards only reg 4 is busy.
  - Storage values are unchanged.
- Reset mid-operation: assert reset=0 for 1 cycle while ready=1 and regs 2 and 4 are busy.
  - ready drops immediately (asynchronous).
  - All busy bits clear.
  - INIT reruns for DEPTH cycles, and every register reads 0 afterwards.
